// File: rtl/led_pwm_driver.sv
// led_pwm_driver
//   Converts per-LED 8-bit brightness values into PWM waveforms. Duties are
//   written over a valid/ready port into shadow registers. They are copied to
//   the active set only at the PWM period boundary, so no period is ever cut
//   short or stretched by a mid-period write.
//
// Parameters
//   NUM_LEDS  number of LED outputs (1..8)
//   PRESCALE  clocks per PWM count minus one
//
// Ports
//   CLK       in   system clock, rising edge
//   RESETN    in   asynchronous active-low reset
//   wr_valid  in   write request
//   wr_ready  out  write accept (high from the first clock after reset)
//   wr_addr   in   LED index
//   wr_duty   in   duty value 0..255
//   wr_err    out  one-cycle pulse when an accepted write had an out-of-range index
//   pending   out  shadow holds an update that has not yet been committed
//   led       out  PWM outputs, active-high, registered
module led_pwm_driver #(
  parameter int NUM_LEDS = 5,
  parameter int PRESCALE = 47
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [2:0]          wr_addr,
  input  logic [7:0]          wr_duty,
  output logic                wr_err,
  output logic                pending,
  output logic [NUM_LEDS-1:0] led
);

  // A zero prescale still needs a one-bit counter so the compare stays legal.
  localparam int              PW        = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);
  localparam logic [PW-1:0]   PS_MAX    = PW'(PRESCALE);
  localparam logic [3:0]      LED_LIMIT = 4'(NUM_LEDS);

  logic [PW-1:0] prescaler;
  logic [7:0]    cnt;
  logic [7:0]    shadow [NUM_LEDS];
  logic [7:0]    active [NUM_LEDS];

  logic tick;
  logic commit;
  logic accept;
  logic addr_ok;

  assign tick    = (prescaler == PS_MAX);
  assign commit  = tick && (cnt == 8'hFF);
  assign accept  = wr_valid && wr_ready;
  assign addr_ok = ({1'b0, wr_addr} < LED_LIMIT);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      prescaler <= '0;
      cnt       <= '0;
      wr_ready  <= 1'b0;
      wr_err    <= 1'b0;
      pending   <= 1'b0;
      led       <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      wr_ready <= 1'b1;

      if (tick) begin
        prescaler <= '0;
        cnt       <= cnt + 8'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      wr_err <= accept && !addr_ok;

      // A write in the commit cycle wins over the clear: its value is still
      // waiting in shadow for the following boundary.
      if (accept && addr_ok) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      for (int i = 0; i < NUM_LEDS; i++) begin
        // Non-blocking read of shadow means the commit takes the pre-write value.
        if (commit) begin
          active[i] <= shadow[i];
        end
        if (accept && addr_ok && (wr_addr == 3'(i))) begin
          shadow[i] <= wr_duty;
        end
        led[i] <= (cnt < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: one PWM count per clock, period 256 clocks.
  logic       rst_n;
  logic       wr_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_duty;
  logic       wr_ready;
  logic       wr_err;
  logic       pending;
  logic [4:0] led;

  // Second instance with PRESCALE=3: period 1024 clocks.
  logic       rst_b_n;
  logic       wv2;
  logic [2:0] wa2;
  logic [7:0] wd2;
  logic       rdy2;
  logic       err2;
  logic       pend2;
  logic [4:0] led2;

  led_pwm_driver #(.NUM_LEDS(5), .PRESCALE(0)) dut (
    .CLK(clk), .RESETN(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_duty(wr_duty), .wr_err(wr_err),
    .pending(pending), .led(led)
  );

  led_pwm_driver #(.NUM_LEDS(5), .PRESCALE(3)) dut_ps (
    .CLK(clk), .RESETN(rst_b_n), .wr_valid(wv2), .wr_ready(rdy2),
    .wr_addr(wa2), .wr_duty(wd2), .wr_err(err2),
    .pending(pend2), .led(led2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model for the main instance. k counts clock edges since reset
  // release; the PWM count in force before edge k+1 is simply k mod 256 and
  // edge k+1 is a period boundary when that count is 255.
  int         k;
  logic [7:0] sh [8];
  logic [7:0] ac [5];
  logic       m_ready, m_err, m_pending;
  logic [4:0] m_led;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= 0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      m_pending <= 1'b0;
      m_led     <= '0;
      for (int i = 0; i < 8; i++) sh[i] <= '0;
      for (int i = 0; i < 5; i++) ac[i] <= '0;
    end else begin : model_step
      int   phase;
      logic acc;
      logic ok;
      phase = k % 256;
      acc   = wr_valid && m_ready;
      ok    = (int'(wr_addr) < 5);
      for (int i = 0; i < 5; i++) begin
        m_led[i] <= (phase < int'(ac[i]));
        if (phase == 255) ac[i] <= sh[i];
      end
      if (acc && ok) begin
        sh[wr_addr] <= wr_duty;
        m_pending   <= 1'b1;
      end else if (phase == 255) begin
        m_pending <= 1'b0;
      end
      m_err   <= acc && !ok;
      m_ready <= 1'b1;
      k       <= k + 1;
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i < 300 && (k % 256) != p; i++) @(negedge clk);
  endtask

  task automatic write_one(input logic [2:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_duty  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 3'd0;
    wr_duty  = 8'd200;
    repeat (3) @(negedge clk);
    n_checks++; if (led !== 5'b0) $display("FAIL reset_led: got %b expected 00000", led); else n_pass++;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", wr_ready); else n_pass++;
    n_checks++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", pending); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL release_ready_early: got %b expected 0", wr_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", wr_ready); else n_pass++;
    wr_valid = 1'b0;
    n_checks++; if (pending !== 1'b0) $display("FAIL reset_no_write: pending got %b expected 0", pending); else n_pass++;
  endtask

  task automatic test_write_mid;
    int early_high;
    int c;
    wait_phase(100);
    write_one(3'd0, 8'd64);
    n_checks++; if (pending !== 1'b1) $display("FAIL mid_pending: got %b expected 1", pending); else n_pass++;
    early_high = 0;
    while ((k % 256) != 0) begin
      if (led[0]) early_high++;
      @(negedge clk);
    end
    if (led[0]) early_high++;
    n_checks++; if (early_high !== 0) $display("FAIL mid_early_led: got %0d high clks expected 0", early_high); else n_pass++;
    n_checks++; if (pending !== 1'b0) $display("FAIL mid_commit_pending: got %b expected 0", pending); else n_pass++;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      c = 0;
      for (int i = 0; i < 256; i++) begin
        if (led[0]) c++;
        @(negedge clk);
      end
      n_checks++; if (c !== 64) $display("FAIL duty64_period%0d: got %0d high clks expected 64", p, c); else n_pass++;
    end
  endtask

  task automatic test_duty_limits;
    int c0, c1, c2;
    wait_phase(50);
    write_one(3'd1, 8'd0);
    write_one(3'd2, 8'd255);
    wait_phase(1);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 768; i++) begin
      if (led[0]) c0++;
      if (led[1]) c1++;
      if (led[2]) c2++;
      @(negedge clk);
    end
    n_checks++; if (c1 !== 0) $display("FAIL duty0: got %0d high clks expected 0", c1); else n_pass++;
    n_checks++; if (c2 !== 765) $display("FAIL duty255: got %0d high clks expected 765", c2); else n_pass++;
    n_checks++; if (c0 !== 192) $display("FAIL duty64_kept: got %0d high clks expected 192", c0); else n_pass++;
  endtask

  task automatic test_last_write_wins;
    int c;
    wait_phase(20);  write_one(3'd0, 8'd10);
    wait_phase(40);  write_one(3'd0, 8'd20);
    wait_phase(60);  write_one(3'd0, 8'd30);
    wait_phase(255); write_one(3'd0, 8'd99);
    n_checks++; if (pending !== 1'b1) $display("FAIL commit_cycle_pending: got %b expected 1", pending); else n_pass++;
    @(negedge clk);
    c = 0;
    for (int i = 0; i < 256; i++) begin
      if (led[0]) c++;
      @(negedge clk);
    end
    n_checks++; if (c !== 30) $display("FAIL last_write: got %0d high clks expected 30", c); else n_pass++;
    n_checks++; if (pending !== 1'b0) $display("FAIL late_commit_pending: got %b expected 0", pending); else n_pass++;
    c = 0;
    for (int i = 0; i < 256; i++) begin
      if (led[0]) c++;
      @(negedge clk);
    end
    n_checks++; if (c !== 99) $display("FAIL commit_cycle_write: got %0d high clks expected 99", c); else n_pass++;
  endtask

  task automatic test_addr_error;
    int c;
    for (int a = 5; a < 8; a++) begin
      write_one(3'(a), 8'd77);
      n_checks++; if (wr_err !== 1'b1) $display("FAIL err_pulse_addr%0d: got %b expected 1", a, wr_err); else n_pass++;
      n_checks++; if (pending !== 1'b0) $display("FAIL err_pending_addr%0d: got %b expected 0", a, pending); else n_pass++;
      @(negedge clk);
      n_checks++; if (wr_err !== 1'b0) $display("FAIL err_width_addr%0d: got %b expected 0", a, wr_err); else n_pass++;
    end
    wait_phase(1);
    c = 0;
    for (int i = 0; i < 256; i++) begin
      if (led[0]) c++;
      @(negedge clk);
    end
    n_checks++; if (c !== 99) $display("FAIL err_no_effect: got %0d high clks expected 99", c); else n_pass++;
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 4000; i++) begin
      n_checks++;
      if ({led, pending, wr_err, wr_ready} !== {m_led, m_pending, m_err, m_ready}) begin
        if (bad < 10)
          $display("FAIL random_cycle%0d: got led=%b pend=%b err=%b rdy=%b expected led=%b pend=%b err=%b rdy=%b",
                   i, led, pending, wr_err, wr_ready, m_led, m_pending, m_err, m_ready);
        bad++;
      end else begin
        n_pass++;
      end
      wr_valid = ($urandom_range(0, 15) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_duty  = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int c;
    wait_phase(100);
    write_one(3'd3, 8'd200);
    n_checks++; if (pending !== 1'b1) $display("FAIL rmid_pending_set: got %b expected 1", pending); else n_pass++;
    wait_phase(150);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (led !== 5'b0) $display("FAIL rmid_led: got %b expected 00000", led); else n_pass++;
    n_checks++; if (pending !== 1'b0) $display("FAIL rmid_pending: got %b expected 0", pending); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && k != 257; i++) @(negedge clk);
    c = 0;
    for (int i = 0; i < 256; i++) begin
      if (led != 5'b0) c++;
      @(negedge clk);
    end
    n_checks++; if (c !== 0) $display("FAIL rmid_update_lost: got %0d lit clks expected 0", c); else n_pass++;
  endtask

  task automatic test_prescale;
    int hi, lo, waited;
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    wv2 = 1'b1; wa2 = 3'd0; wd2 = 8'd128;
    @(negedge clk);
    wv2 = 1'b0;
    n_checks++; if (pend2 !== 1'b1) $display("FAIL ps_pending: got %b expected 1", pend2); else n_pass++;
    waited = 0;
    while (led2[0] !== 1'b1 && waited < 1200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (waited >= 1200) $display("FAIL ps_rise_timeout: waited %0d clks expected under 1200", waited); else n_pass++;
    hi = 0;
    while (led2[0] === 1'b1 && hi < 2000) begin
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (led2[0] === 1'b0 && lo < 2000) begin
      lo++;
      @(negedge clk);
    end
    n_checks++; if (hi !== 512) $display("FAIL ps_high: got %0d clks expected 512", hi); else n_pass++;
    n_checks++; if (lo !== 512) $display("FAIL ps_low: got %0d clks expected 512", lo); else n_pass++;
    repeat (100) @(negedge clk);
    n_checks++; if (led2[0] !== 1'b1) $display("FAIL ps_mid_high: got %b expected 1", led2[0]); else n_pass++;
    #2 rst_b_n = 1'b0;
    #1;
    n_checks++; if (led2 !== 5'b0) $display("FAIL ps_async_led: got %b expected 00000", led2); else n_pass++;
    n_checks++; if (rdy2 !== 1'b0) $display("FAIL ps_async_ready: got %b expected 0", rdy2); else n_pass++;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_duty  = '0;
    rst_b_n  = 1'b0;
    wv2      = 1'b0;
    wa2      = '0;
    wd2      = '0;
    @(negedge clk);
    test_reset;
    test_write_mid;
    test_duty_limits;
    test_last_write_wins;
    test_addr_error;
    test_random;
    test_reset_mid;
    test_prescale;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
